mem_arbiter: RTL
================

# mem_arbiter

Shares one external memory bus between the instruction-fetch port and the MEM-stage data port. The MEM stage drives a byte-lane load/store request (address, we, sel, write data) and the fetch unit drives word fetches. The arbiter serialises both onto a single request/ack bus. It returns read data and raises per-port stall requests to the pipeline controller until each access completes. It sits between the core (if/mem stages) and the SRAM/bus bridge.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: bus cycles with bus_req_o high and no ack before abort. Range 1..255; used only with the timeout feature.

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_ce_i  in  1  fetch request
- inst_addr_i  in  32  fetch address, word-aligned
- inst_data_o  out  32  fetched word, registered
- stallreq_inst_o  out  1  stall pipeline for fetch
- flush_i  in  1  discard the in-flight fetch result
- data_ce_i  in  1  MEM-stage access request
- data_we_i  in  1  1 = store
- data_addr_i  in  32  data address
- data_sel_i  in  4  byte enables; bit3 = byte at addr[1:0]=00
- data_wdata_i  in  32  store data, lanes pre-replicated
- data_rdata_o  out  32  load word, registered, raw lanes
- stallreq_data_o  out  1  stall pipeline for data access
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  32  bus address
- bus_sel_o  out  4  bus byte enables
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data, valid with ack
- bus_ack_i  in  1  completes the current bus cycle
- bus_err_o  out  1  one-cycle timeout pulse

## Operation
- States: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE.
- IDLE: if data_ce_i is high, latch the data request, assert bus_req_o, go to D_BUSY. Otherwise, if inst_ce_i is high, latch the fetch with bus_we_o=0 and bus_sel_o=4'b1111, go to I_BUSY. Data always wins simultaneous requests.
- D_BUSY/I_BUSY: all bus_* outputs stay stable. Input changes are ignored. When bus_ack_i is sampled high:
  - deassert bus_req_o;
  - for a load, capture bus_rdata_i into data_rdata_o; for a fetch, capture it into inst_data_o;
  - go to D_DONE or I_DONE.
- Stores do not modify data_rdata_o.
- No preemption: a data request arriving during I_BUSY waits until the fetch finishes. It is then served from IDLE.
- flush_i high in any cycle of I_BUSY marks the fetch as flushed. On ack the arbiter goes straight to IDLE, and inst_data_o stays unchanged. flush_i has no effect on data accesses.
- D_DONE/I_DONE: last one cycle, then go to IDLE.
- stallreq_data_o = data_ce_i && state != D_DONE (combinational).
- stallreq_inst_o = inst_ce_i && state != I_DONE (combinational).
- Reset values: state IDLE, and every output 0, including bus_req_o, inst_data_o, data_rdata_o and bus_err_o. Stall outputs follow their formulas, so they can be high during reset if a request input is high.

## Timing
- Request seen in IDLE at cycle N gives bus_req_o high at N+1.
- bus_ack_i may be high in any cycle in which bus_req_o is high, including N+1.
- Ack at cycle M gives the DONE state and registered data at M+1, with the stall low during M+1. The arbiter is back in IDLE at M+2.
- The minimum access therefore takes 3 cycles (N, N+1, N+2) and the port is stalled for 2 of them.
- Back-to-back: from IDLE at M+2 the next request is launched. Throughput is one access per 3 cycles with a zero-wait bus.
- bus_ack_i is ignored when bus_req_o is low.
- Reset asserted mid-access drops bus_req_o immediately (asynchronous). The access is lost with no retry.

## Configuration
- MEMARB_TIMEOUT_EN defined: an 8-bit counter
  - clears when a BUSY state is entered;
  - increments each BUSY cycle without ack.
- When the counter reaches TIMEOUT_CYCLES, the arbiter:
  - deasserts bus_req_o;
  - pulses bus_err_o for one cycle;
  - loads 0 into the target read register (not for stores or flushed fetches);
  - proceeds to the DONE state (IDLE if the fetch is flushed), exactly as if acked.
- Ack and timeout in the same cycle: the ack wins.
- MEMARB_TIMEOUT_EN undefined: bus_err_o is tied 0, no counter is built, and the arbiter waits indefinitely.

## Structure
- State encodings (3-bit) and the MEMARB_TIMEOUT_EN default go in the shared defines.v, next to RegBus and ChipEnable.
- One sub-module, mem_arb_timer (counter plus terminal-count compare), instantiated only under the macro.

## Test plan
- Fetch 0x0000_0100, ack on first req cycle with rdata 0x2402_0005 -> inst_data_o=0x2402_0005 at cycle N+2; stallreq_inst_o high N..N+1, low N+2.
- data_ce_i and inst_ce_i both high, store addr 0x10 sel 4'b0011 wdata 0xBEEF_BEEF -> bus shows the data request first with bus_we_o=1, the fetch is launched two cycles after the data ack, and data_rdata_o is unchanged.
- Load at 0x20, ack delayed 5 cycles, rdata 0x1122_3344 -> bus outputs stable 5 cycles, data_rdata_o=0x1122_3344, stallreq_data_o low exactly one cycle.
- Fetch in flight, flush_i pulsed 1 cycle, ack later with 0xFFFF_FFFF -> inst_data_o keeps the old value and no I_DONE cycle occurs.
- Reset (rst=0) asserted mid-D_BUSY -> bus_req_o 0 in the same cycle, all outputs 0, and after release a new fetch proceeds normally.
- With MEMARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> bus_req_o drops after 4 BUSY cycles, bus_err_o pulses once, data_rdata_o=0; without the macro, bus_req_o stays high.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory bus arbiter.
//   arb_state_e      3-bit arbiter state encoding
//   TIMEOUT_DEFAULT  default bus timeout in cycles
//   SEL_WORD         full-word byte enables used for instruction fetches
//   TIMER_W          width of the optional timeout counter
// The optional timeout feature is controlled by the macro MEMARB_TIMEOUT_EN.
// It is left undefined by default, so the feature is off unless the build
// defines the macro.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_BUSY = 3'd1,
        I_BUSY = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } arb_state_e;

    localparam int         TIMEOUT_DEFAULT = 255;
    localparam logic [3:0] SEL_WORD        = 4'b1111;
    localparam int         TIMER_W         = 8;

endpackage

// File: rtl/mem_arbiter_timer.sv
// mem_arb_timer: bus timeout counter with terminal-count compare.
// It is instantiated only when MEMARB_TIMEOUT_EN is defined.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   clear    restart the count (a bus cycle is being launched)
//   busy     arbiter is in a BUSY state
//   ack      qualified bus acknowledge
//   expired  this BUSY cycle is the TIMEOUT_CYCLES-th cycle without an ack
module mem_arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    // The count holds the number of completed un-acked BUSY cycles, so the
    // terminal cycle is the one in which the count equals TIMEOUT_CYCLES-1.
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (busy && !ack) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = busy && !ack && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one request/ack memory bus between the instruction
// fetch port and the MEM-stage data port. Data requests win ties. There is
// no preemption, and each access ends with a one-cycle DONE state in which
// that port's stall drops.
// Optional feature: define MEMARB_TIMEOUT_EN to abort bus cycles that see no
// ack within TIMEOUT_CYCLES. bus_err_o then pulses and the target read
// register loads zero.
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   inst_ce_i/inst_addr_i     fetch request and word address
//   inst_data_o               fetched word (registered)
//   stallreq_inst_o           fetch stall (combinational)
//   flush_i                   drop the result of the in-flight fetch
//   data_ce_i/we/addr/sel/wdata  MEM-stage load/store request
//   data_rdata_o              loaded word, raw lanes (registered)
//   stallreq_data_o           data stall (combinational)
//   bus_req/we/addr/sel/wdata_o  registered bus request
//   bus_rdata_i/bus_ack_i     bus response
//   bus_err_o                 one-cycle timeout pulse
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ce_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        stallreq_inst_o,
    input  logic        flush_i,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        stallreq_data_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must lie in 1..255");
    end

    arb_state_e state;
    logic       flushed;
    logic       launch;
    logic       in_busy;
    logic       ack;
    logic       timeout;
    logic       drop_fetch;

    assign launch  = (state == IDLE) && (data_ce_i || inst_ce_i);
    assign in_busy = (state == D_BUSY) || (state == I_BUSY);
    // An ack only counts while a request is actually on the bus.
    assign ack     = bus_ack_i && bus_req_o;
    // A flush in the completing cycle itself also discards the fetch.
    assign drop_fetch = flushed || flush_i;

`ifdef MEMARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (launch),
        .busy    (in_busy),
        .ack     (ack),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    assign stallreq_data_o = data_ce_i && (state != D_DONE);
    assign stallreq_inst_o = inst_ce_i && (state != I_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            flushed      <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_sel_o    <= '0;
            bus_wdata_o  <= '0;
            inst_data_o  <= '0;
            data_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flushed <= 1'b0;
                    if (data_ce_i) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= data_we_i;
                        bus_addr_o  <= data_addr_i;
                        bus_sel_o   <= data_sel_i;
                        bus_wdata_o <= data_wdata_i;
                        state       <= D_BUSY;
                    end else if (inst_ce_i) begin
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= inst_addr_i;
                        bus_sel_o   <= SEL_WORD;
                        bus_wdata_o <= '0;
                        state       <= I_BUSY;
                    end
                end
                D_BUSY: begin
                    if (ack || timeout) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            data_rdata_o <= ack ? bus_rdata_i : '0;
                        end
                        state <= D_DONE;
                    end
                end
                I_BUSY: begin
                    if (flush_i) begin
                        flushed <= 1'b1;
                    end
                    if (ack || timeout) begin
                        bus_req_o <= 1'b0;
                        if (drop_fetch) begin
                            state <= IDLE;
                        end else begin
                            inst_data_o <= ack ? bus_rdata_i : '0;
                            state       <= I_DONE;
                        end
                    end
                end
                D_DONE, I_DONE: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

endmodule
